ddr_burst_rd_engine: RTL and testbench

// Parametrised MIG read-burst engine: fetches BURST_LEN words per request from one of NUM_BUF frame buffers.

---
 rtl/ddr_burst_rd_engine.sv | 190 +++++++++++++++++++
 tb/tb_ddr_burst_rd_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_rd_engine.sv
// MIG read-burst engine: arbitrates for the DDR port, issues BURST_LEN credit-gated read
// commands into a frame buffer and finishes once all read data for the burst has returned.
module ddr_burst_rd_engine #(
    parameter int unsigned ADDR_W       = 29,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned BURST_LEN    = 64,
    parameter int unsigned ADDR_STEP    = 8,
    parameter int unsigned FRAME_WORDS  = 98304,
    parameter int unsigned NUM_BUF      = 2,
    parameter int unsigned CREDIT_DEPTH = 128,
    localparam int unsigned BUF_W       = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic              ui_clk,
    input  logic              rst_n,
    input  logic              rd_start,
    input  logic [BUF_W-1:0]  buf_sel,
    output logic              rd_req,
    input  logic              rd_ack,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              rd_frame_end,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic              app_rd_data_vld,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              dn_credit_ret,
    output logic              rd_ddr_data_vld,
    output logic [DATA_W-1:0] rd_ddr_data
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned OFF_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned CRD_W = $clog2(CREDIT_DEPTH + 1);

    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(FRAME_WORDS - 1);
    localparam logic [CRD_W-1:0] CRD_FULL  = CRD_W'(CREDIT_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StRdReq,
        StIssue,
        StDrain
    } state_e;

    state_e             state_q, state_d;
    logic               rd_req_q, rd_req_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [OFF_W-1:0]   offset_q, offset_d;
    logic [CNT_W-1:0]   cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
    logic [CRD_W-1:0]   credits_q, credits_d;
    logic               frame_wrap_q, frame_wrap_d;
    logic               rd_done_q, rd_done_d;
    logic               rd_frame_end_q, rd_frame_end_d;
    logic               rd_ddr_data_vld_q;
    logic [DATA_W-1:0]  rd_ddr_data_q;

    logic               accept;
    logic               active;
    logic               burst_cmp;

    // Only register state feeds app_en, so a raised command cannot drop before it is accepted.
    assign app_en    = (state_q == StIssue) && (cmd_cnt_q < BURST_CNT) && (credits_q != '0);
    assign accept    = app_en && app_rdy;
    assign active    = (state_q == StIssue) || (state_q == StDrain);
    assign burst_cmp = (state_q == StDrain) && (data_cnt_q == BURST_CNT);

    assign app_addr = ADDR_W'((ADDR_W'(buf_q) * ADDR_W'(FRAME_WORDS) + ADDR_W'(offset_q))
                              * ADDR_W'(ADDR_STEP));

    assign app_cmd         = 3'b001;
    assign rd_req          = rd_req_q;
    assign rd_busy         = active;
    assign rd_done         = rd_done_q;
    assign rd_frame_end    = rd_frame_end_q;
    assign rd_ddr_data_vld = rd_ddr_data_vld_q;
    assign rd_ddr_data     = rd_ddr_data_q;

    always_comb begin
        state_d        = state_q;
        rd_req_d       = rd_req_q;
        buf_d          = buf_q;
        offset_d       = offset_q;
        cmd_cnt_d      = cmd_cnt_q;
        data_cnt_d     = data_cnt_q;
        credits_d      = credits_q;
        frame_wrap_d   = frame_wrap_q;
        rd_done_d      = 1'b0;
        rd_frame_end_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rd_start) begin
                    state_d = StRdReq;
                    buf_d   = buf_sel;
                    if (buf_sel != buf_q) begin
                        offset_d = '0;
                    end
                end
            end
            StRdReq: begin
                if (rd_ack) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (accept && (cmd_cnt_q == CMD_LAST)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (burst_cmp) begin
                    state_d        = StIdle;
                    rd_done_d      = 1'b1;
                    rd_frame_end_d = frame_wrap_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // A grant in any state drops the request; a new start in IDLE re-arms it.
        if (rd_ack) begin
            rd_req_d = 1'b0;
        end
        if ((state_q == StIdle) && rd_start) begin
            rd_req_d = 1'b1;
        end

        if (accept) begin
            cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
            if (offset_q == OFF_LAST) begin
                offset_d     = '0;
                frame_wrap_d = 1'b1;
            end else begin
                offset_d = offset_q + OFF_W'(1);
            end
        end

        if (accept && !dn_credit_ret) begin
            credits_d = credits_q - CRD_W'(1);
        end else if (!accept && dn_credit_ret && (credits_q != CRD_FULL)) begin
            credits_d = credits_q + CRD_W'(1);
        end

        if (app_rd_data_vld && active && (data_cnt_q != BURST_CNT)) begin
            data_cnt_d = data_cnt_q + CNT_W'(1);
        end

        if (burst_cmp) begin
            cmd_cnt_d    = '0;
            data_cnt_d   = '0;
            frame_wrap_d = 1'b0;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            rd_req_q          <= 1'b0;
            buf_q             <= '0;
            offset_q          <= '0;
            cmd_cnt_q         <= '0;
            data_cnt_q        <= '0;
            credits_q         <= CRD_FULL;
            frame_wrap_q      <= 1'b0;
            rd_done_q         <= 1'b0;
            rd_frame_end_q    <= 1'b0;
            rd_ddr_data_vld_q <= 1'b0;
            rd_ddr_data_q     <= '0;
        end else begin
            state_q           <= state_d;
            rd_req_q          <= rd_req_d;
            buf_q             <= buf_d;
            offset_q          <= offset_d;
            cmd_cnt_q         <= cmd_cnt_d;
            data_cnt_q        <= data_cnt_d;
            credits_q         <= credits_d;
            frame_wrap_q      <= frame_wrap_d;
            rd_done_q         <= rd_done_d;
            rd_frame_end_q    <= rd_frame_end_d;
            rd_ddr_data_vld_q <= app_rd_data_vld;
            rd_ddr_data_q     <= app_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr_burst_rd_engine.sv
// Directed bench for ddr_burst_rd_engine with a small frame (8 words), 4-word bursts and
// 2 downstream credits.
module tb_ddr_burst_rd_engine;

    localparam int unsigned ADDR_W = 29;
    localparam int unsigned DATA_W = 16;

    logic              ui_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rd_start = 1'b0;
    logic              buf_sel = 1'b0;
    logic              rd_req;
    logic              rd_ack = 1'b0;
    logic              rd_busy;
    logic              rd_done;
    logic              rd_frame_end;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy = 1'b0;
    logic              app_rd_data_vld = 1'b0;
    logic [DATA_W-1:0] app_rd_data = '0;
    logic              dn_credit_ret = 1'b0;
    logic              rd_ddr_data_vld;
    logic [DATA_W-1:0] rd_ddr_data;

    int n_tests = 0;
    int n_fail  = 0;

    ddr_burst_rd_engine #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BURST_LEN   (4),
        .ADDR_STEP   (8),
        .FRAME_WORDS (8),
        .NUM_BUF     (2),
        .CREDIT_DEPTH(2)
    ) dut (
        .ui_clk         (ui_clk),
        .rst_n          (rst_n),
        .rd_start       (rd_start),
        .buf_sel        (buf_sel),
        .rd_req         (rd_req),
        .rd_ack         (rd_ack),
        .rd_busy        (rd_busy),
        .rd_done        (rd_done),
        .rd_frame_end   (rd_frame_end),
        .app_cmd        (app_cmd),
        .app_en         (app_en),
        .app_addr       (app_addr),
        .app_rdy        (app_rdy),
        .app_rd_data_vld(app_rd_data_vld),
        .app_rd_data    (app_rd_data),
        .dn_credit_ret  (dn_credit_ret),
        .rd_ddr_data_vld(rd_ddr_data_vld),
        .rd_ddr_data    (rd_ddr_data)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic bsel);
        buf_sel  = bsel;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ack   = 1'b1;
        tick();
        rd_ack   = 1'b0;
    endtask

    // Full burst with a 2-cycle read latency; each returned word also returns a credit.
    task automatic run_burst(input logic bsel, input logic [ADDR_W-1:0] base, input logic exp_fe,
                             input string tag);
        int             acc = 0;
        int             dones = 0;
        int             lat_q[$];
        logic           fe_seen = 1'b0;
        logic           drv_vld;
        logic [DATA_W-1:0] drv_data;
        buf_sel  = bsel;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check({tag, ".req"}, 64'(rd_req), 64'(1'b1));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check({tag, ".req_clr"}, 64'(rd_req), 64'(1'b0));
        check({tag, ".busy"}, 64'(rd_busy), 64'(1'b1));
        app_rdy = 1'b1;
        for (int cyc = 0; cyc < 60 && dones == 0; cyc++) begin
            if (app_en) begin
                check({tag, ".addr"}, 64'(app_addr), 64'(base + ADDR_W'(8 * acc)));
                acc++;
                lat_q.push_back(cyc + 2);
            end
            drv_vld  = 1'b0;
            drv_data = DATA_W'(16'hD000 + cyc);
            if (lat_q.size() > 0 && lat_q[0] == cyc) begin
                void'(lat_q.pop_front());
                drv_vld = 1'b1;
            end
            app_rd_data_vld = drv_vld;
            app_rd_data     = drv_data;
            dn_credit_ret   = drv_vld;
            tick();
            check({tag, ".fwd_vld"}, 64'(rd_ddr_data_vld), 64'(drv_vld));
            if (drv_vld) begin
                check({tag, ".fwd_data"}, 64'(rd_ddr_data), 64'(drv_data));
            end
            if (rd_done) begin
                dones++;
                fe_seen = rd_frame_end;
            end
        end
        app_rdy         = 1'b0;
        app_rd_data_vld = 1'b0;
        dn_credit_ret   = 1'b0;
        check({tag, ".done_cnt"}, 64'(dones), 64'(1));
        check({tag, ".accepts"}, 64'(acc), 64'(4));
        check({tag, ".frame_end"}, 64'(fe_seen), 64'(exp_fe));
        check({tag, ".idle_busy"}, 64'(rd_busy), 64'(1'b0));
        tick();
        check({tag, ".done_pulse"}, 64'(rd_done), 64'(1'b0));
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst.req", 64'(rd_req), 64'(1'b0));
        check("rst.busy", 64'(rd_busy), 64'(1'b0));
        check("rst.done", 64'(rd_done), 64'(1'b0));
        check("rst.fe", 64'(rd_frame_end), 64'(1'b0));
        check("rst.en", 64'(app_en), 64'(1'b0));
        check("rst.cmd", 64'(app_cmd), 64'(3'b001));
        check("rst.addr", 64'(app_addr), 64'(0));
        check("rst.fwd", 64'(rd_ddr_data_vld), 64'(1'b0));
        rst_n = 1'b1;
        tick();

        // Sequential bursts in buffer 0, frame wrap, then buffer switch
        run_burst(1'b0, ADDR_W'(0), 1'b0, "t1");
        run_burst(1'b0, ADDR_W'(32), 1'b1, "t2");
        run_burst(1'b0, ADDR_W'(0), 1'b0, "t2b");
        run_burst(1'b1, ADDR_W'(64), 1'b0, "t3");

        // Credit gating: buffer 0 again, offset cleared by the switch
        start_burst(1'b0);
        check("t4.en0", 64'(app_en), 64'(1'b1));
        check("t4.addr0", 64'(app_addr), 64'(0));
        app_rdy = 1'b1;
        tick();
        check("t4.en1", 64'(app_en), 64'(1'b1));
        check("t4.addr1", 64'(app_addr), 64'(8));
        tick();
        check("t4.nocred", 64'(app_en), 64'(1'b0));
        tick();
        tick();
        check("t4.nocred_hold", 64'(app_en), 64'(1'b0));
        check("t4.busy", 64'(rd_busy), 64'(1'b1));
        app_rdy       = 1'b0;
        dn_credit_ret = 1'b1;
        tick();
        dn_credit_ret = 1'b0;
        check("t4.ret_en", 64'(app_en), 64'(1'b1));
        check("t4.addr2", 64'(app_addr), 64'(16));
        app_rdy       = 1'b1;
        dn_credit_ret = 1'b1;
        tick();
        dn_credit_ret = 1'b0;
        check("t4.simul_en", 64'(app_en), 64'(1'b1));
        check("t4.addr3", 64'(app_addr), 64'(24));
        tick();
        app_rdy = 1'b0;
        check("t4.drain_en", 64'(app_en), 64'(1'b0));
        check("t4.drain_busy", 64'(rd_busy), 64'(1'b1));
        check("t4.drain_done", 64'(rd_done), 64'(1'b0));
        for (int i = 0; i < 4; i++) begin
            app_rd_data_vld = 1'b1;
            app_rd_data     = DATA_W'(16'h4A00 + i);
            dn_credit_ret   = 1'b1;
            tick();
        end
        app_rd_data_vld = 1'b0;
        dn_credit_ret   = 1'b0;
        check("t4.pre_done", 64'(rd_done), 64'(1'b0));
        check("t4.pre_busy", 64'(rd_busy), 64'(1'b1));
        tick();
        check("t4.done", 64'(rd_done), 64'(1'b1));
        check("t4.fe", 64'(rd_frame_end), 64'(1'b0));
        check("t4.idle", 64'(rd_busy), 64'(1'b0));
        tick();
        check("t4.done_pulse", 64'(rd_done), 64'(1'b0));

        // Stalled app_rdy, credit cap, delayed data; this burst ends the frame
        start_burst(1'b0);
        check("t5.addr0", 64'(app_addr), 64'(32));
        app_rdy = 1'b1;
        tick();
        check("t5.en1", 64'(app_en), 64'(1'b1));
        check("t5.addr1", 64'(app_addr), 64'(40));
        app_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5.stall_en", 64'(app_en), 64'(1'b1));
            check("t5.stall_addr", 64'(app_addr), 64'(40));
        end
        app_rdy = 1'b1;
        tick();
        check("t5.cap_en", 64'(app_en), 64'(1'b0));
        dn_credit_ret = 1'b1;
        tick();
        check("t5.en2", 64'(app_en), 64'(1'b1));
        check("t5.addr2", 64'(app_addr), 64'(48));
        tick();
        dn_credit_ret = 1'b0;
        check("t5.en3", 64'(app_en), 64'(1'b1));
        check("t5.addr3", 64'(app_addr), 64'(56));
        tick();
        app_rdy = 1'b0;
        check("t5.drain_en", 64'(app_en), 64'(1'b0));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5.wait_done", 64'(rd_done), 64'(1'b0));
        end
        check("t5.wait_busy", 64'(rd_busy), 64'(1'b1));
        for (int i = 0; i < 4; i++) begin
            app_rd_data_vld = 1'b1;
            app_rd_data     = DATA_W'(16'h5B00 + i);
            dn_credit_ret   = 1'b1;
            tick();
            check("t5.fwd_vld", 64'(rd_ddr_data_vld), 64'(1'b1));
            check("t5.fwd_data", 64'(rd_ddr_data), 64'(16'h5B00 + i));
        end
        app_rd_data_vld = 1'b0;
        dn_credit_ret   = 1'b0;
        check("t5.pre_done", 64'(rd_done), 64'(1'b0));
        tick();
        check("t5.fwd_idle", 64'(rd_ddr_data_vld), 64'(1'b0));
        check("t5.done", 64'(rd_done), 64'(1'b1));
        check("t5.fe", 64'(rd_frame_end), 64'(1'b1));
        check("t5.idle", 64'(rd_busy), 64'(1'b0));
        tick();
        check("t5.done_pulse", 64'(rd_done), 64'(1'b0));
        check("t5.fe_pulse", 64'(rd_frame_end), 64'(1'b0));

        // Reset while draining
        start_burst(1'b0);
        check("t6.addr0", 64'(app_addr), 64'(0));
        app_rdy = 1'b1;
        tick();
        tick();
        check("t6.nocred", 64'(app_en), 64'(1'b0));
        dn_credit_ret = 1'b1;
        tick();
        tick();
        tick();
        dn_credit_ret = 1'b0;
        app_rdy       = 1'b0;
        check("t6.drain_en", 64'(app_en), 64'(1'b0));
        check("t6.drain_busy", 64'(rd_busy), 64'(1'b1));
        app_rd_data_vld = 1'b1;
        app_rd_data     = DATA_W'(16'h6C00);
        tick();
        app_rd_data_vld = 1'b0;
        check("t6.busy_mid", 64'(rd_busy), 64'(1'b1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6.rst_busy", 64'(rd_busy), 64'(1'b0));
        check("t6.rst_en", 64'(app_en), 64'(1'b0));
        check("t6.rst_req", 64'(rd_req), 64'(1'b0));
        check("t6.rst_done", 64'(rd_done), 64'(1'b0));
        for (int i = 1; i < 4; i++) begin
            app_rd_data_vld = 1'b1;
            app_rd_data     = DATA_W'(16'h6C00 + i);
            tick();
            check("t6.stray_fwd", 64'(rd_ddr_data_vld), 64'(1'b1));
            check("t6.stray_done", 64'(rd_done), 64'(1'b0));
        end
        app_rd_data_vld = 1'b0;
        tick();
        tick();
        check("t6.after_done", 64'(rd_done), 64'(1'b0));
        check("t6.after_busy", 64'(rd_busy), 64'(1'b0));
        start_burst(1'b0);
        check("t6.new_en0", 64'(app_en), 64'(1'b1));
        check("t6.new_addr0", 64'(app_addr), 64'(0));
        app_rdy = 1'b1;
        tick();
        check("t6.new_en1", 64'(app_en), 64'(1'b1));
        check("t6.new_addr1", 64'(app_addr), 64'(8));
        tick();
        app_rdy = 1'b0;
        check("t6.new_cred", 64'(app_en), 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
